// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter
// Shares one downstream cache-style memory port (one read channel, one write
// channel) between the instruction-fetch side (I) and the data side (D).
// - One read transaction at a time; return beats are routed back to the
//   requester that owns the grant.
// - One outstanding write is tracked. A D read to the same line is held off
//   until the downstream reports the write as complete (wr_done).
// Optional build macro: ARB_RR_EN
//   defined   : round-robin between simultaneous, non-hazarded I and D reads
//   undefined : fixed priority, D over I
module mem_req_arbiter #(
    parameter int LINE_OFF = 4
) (
    input  logic         clk,
    input  logic         resetn,

    // instruction-side read port
    input  logic         i_rd_req,
    input  logic [2:0]   i_rd_type,
    input  logic [31:0]  i_rd_addr,
    output logic         i_rd_rdy,
    output logic         i_ret_valid,
    output logic         i_ret_last,

    // data-side read port
    input  logic         d_rd_req,
    input  logic [2:0]   d_rd_type,
    input  logic [31:0]  d_rd_addr,
    output logic         d_rd_rdy,
    output logic         d_ret_valid,
    output logic         d_ret_last,

    // return data shared by both sides, qualified by *_ret_valid
    output logic [31:0]  ret_data,

    // data-side write port
    input  logic         d_wr_req,
    input  logic [2:0]   d_wr_type,
    input  logic [31:0]  d_wr_addr,
    input  logic [3:0]   d_wr_wstrb,
    input  logic [127:0] d_wr_data,
    output logic         d_wr_rdy,

    // downstream read channel
    output logic         rd_req,
    output logic [2:0]   rd_type,
    output logic [31:0]  rd_addr,
    input  logic         rd_rdy,
    input  logic         ret_valid,
    input  logic         ret_last,
    input  logic [31:0]  ret_data_in,

    // downstream write channel
    output logic         wr_req,
    output logic [2:0]   wr_type,
    output logic [31:0]  wr_addr,
    output logic [3:0]   wr_wstrb,
    output logic [127:0] wr_data,
    input  logic         wr_rdy,
    input  logic         wr_done
);

    localparam int TAG_W = 32 - LINE_OFF;

    // read FSM encoding
    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_RESP = 2'd2;

    // write FSM encoding
    localparam logic W_IDLE = 1'b0;
    localparam logic W_WAIT = 1'b1;

    // grant owner encoding
    localparam logic [1:0] G_NONE = 2'd0;
    localparam logic [1:0] G_I    = 2'd1;
    localparam logic [1:0] G_D    = 2'd2;

    // ------------------------------------------------------------------
    // state
    // ------------------------------------------------------------------
    logic [1:0]       r_state_reg,   r_state_next;
    logic [1:0]       grant_reg,     grant_next;
    logic [2:0]       rd_type_reg,   rd_type_next;
    logic [31:0]      rd_addr_reg,   rd_addr_next;
    logic             w_state_reg,   w_state_next;
    logic             pend_reg,      pend_next;
    logic [TAG_W-1:0] pend_line_reg, pend_line_next;
`ifdef ARB_RR_EN
    logic [1:0]       last_grant_reg, last_grant_next;
`endif

    // ------------------------------------------------------------------
    // arbitration terms
    // ------------------------------------------------------------------
    logic             wr_pass;
    logic             wr_accept;
    logic             hazard_pend;
    logic             hazard_new;
    logic             hazard;
    logic             d_ok;
    logic             i_ok;
    logic             pick_d;
    logic             in_resp;

    // Write pass-through is only live in W_IDLE; resetn gates it so every
    // output is zero the moment reset is asserted, whatever the inputs do.
    assign wr_pass   = (w_state_reg == W_IDLE) && d_wr_req && resetn;
    assign wr_accept = wr_pass && wr_rdy;

    // A D read conflicts with the write already outstanding, or with a write
    // being accepted this very cycle (the write wins that race).
    assign hazard_pend = pend_reg &&
                         (d_rd_addr[31:LINE_OFF] == pend_line_reg);
    assign hazard_new  = wr_accept &&
                         (d_rd_addr[31:LINE_OFF] == d_wr_addr[31:LINE_OFF]);
    assign hazard      = d_rd_req && (hazard_pend || hazard_new);

    assign d_ok = d_rd_req && !hazard;
    assign i_ok = i_rd_req;

`ifdef ARB_RR_EN
    // On a tie the side that did not win last time goes first.
    assign pick_d = d_ok && (!i_ok || (last_grant_reg == G_I));
`else
    // Fixed priority: the data side always wins a tie.
    assign pick_d = d_ok;
`endif

    assign in_resp = (r_state_reg == R_RESP);

    // Read FSM next-state: sample in R_IDLE, present in R_REQ, stream in R_RESP.
    always_comb begin
        r_state_next = r_state_reg;
        grant_next   = grant_reg;
        rd_type_next = rd_type_reg;
        rd_addr_next = rd_addr_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (pick_d) begin
                    grant_next   = G_D;
                    rd_type_next = d_rd_type;
                    rd_addr_next = d_rd_addr;
                    r_state_next = R_REQ;
                end else if (i_ok) begin
                    grant_next   = G_I;
                    rd_type_next = i_rd_type;
                    rd_addr_next = i_rd_addr;
                    r_state_next = R_REQ;
                end
            end
            R_REQ: begin
                if (rd_rdy) begin
                    r_state_next = R_RESP;
                end
            end
            R_RESP: begin
                if (ret_valid && ret_last) begin
                    r_state_next = R_IDLE;
                    grant_next   = G_NONE;
                end
            end
            default: begin
                r_state_next = R_IDLE;
                grant_next   = G_NONE;
            end
        endcase
    end

`ifdef ARB_RR_EN
    // Remember who won the most recent grant for the next tie-break.
    always_comb begin
        last_grant_next = last_grant_reg;
        if (r_state_reg == R_IDLE) begin
            if (pick_d) begin
                last_grant_next = G_D;
            end else if (i_ok) begin
                last_grant_next = G_I;
            end
        end
    end
`endif

    // Write FSM next-state: accept one write, then wait for its completion.
    always_comb begin
        w_state_next   = w_state_reg;
        pend_next      = pend_reg;
        pend_line_next = pend_line_reg;
        case (w_state_reg)
            W_IDLE: begin
                if (wr_accept) begin
                    w_state_next   = W_WAIT;
                    pend_next      = 1'b1;
                    pend_line_next = d_wr_addr[31:LINE_OFF];
                end
            end
            W_WAIT: begin
                if (wr_done) begin
                    w_state_next = W_IDLE;
                    pend_next    = 1'b0;
                end
            end
            default: begin
                w_state_next = W_IDLE;
                pend_next    = 1'b0;
            end
        endcase
    end

    // Read-side registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state_reg <= R_IDLE;
            grant_reg   <= G_NONE;
            rd_type_reg <= 3'd0;
            rd_addr_reg <= 32'd0;
        end else begin
            r_state_reg <= r_state_next;
            grant_reg   <= grant_next;
            rd_type_reg <= rd_type_next;
            rd_addr_reg <= rd_addr_next;
        end
    end

`ifdef ARB_RR_EN
    // Round-robin history register; I counts as the previous winner out of reset.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_reg <= G_I;
        end else begin
            last_grant_reg <= last_grant_next;
        end
    end
`endif

    // Write-side registers, cleared asynchronously.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_state_reg   <= W_IDLE;
            pend_reg      <= 1'b0;
            pend_line_reg <= '0;
        end else begin
            w_state_reg   <= w_state_next;
            pend_reg      <= pend_next;
            pend_line_reg <= pend_line_next;
        end
    end

    // ------------------------------------------------------------------
    // per-side routing: index 0 is the I side, index 1 the D side
    // ------------------------------------------------------------------
    logic [1:0] side_rdy;
    logic [1:0] side_ret_valid;
    logic [1:0] side_ret_last;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_side
            localparam logic [1:0] CODE = (gi == 0) ? G_I : G_D;
            // Accept pulse and return beats only reach the grant owner.
            assign side_rdy[gi]       = (r_state_reg == R_REQ) && rd_rdy &&
                                        (grant_reg == CODE);
            assign side_ret_valid[gi] = in_resp && ret_valid &&
                                        (grant_reg == CODE);
            assign side_ret_last[gi]  = in_resp && ret_valid && ret_last &&
                                        (grant_reg == CODE);
        end
    endgenerate

    assign i_rd_rdy    = side_rdy[0];
    assign d_rd_rdy    = side_rdy[1];
    assign i_ret_valid = side_ret_valid[0];
    assign d_ret_valid = side_ret_valid[1];
    assign i_ret_last  = side_ret_last[0];
    assign d_ret_last  = side_ret_last[1];

    // Return data is only forwarded while a response is being streamed, so
    // stray beats outside R_RESP never leak upstream.
    assign ret_data = in_resp ? ret_data_in : 32'd0;

    // downstream read request
    assign rd_req  = (r_state_reg == R_REQ);
    assign rd_type = rd_type_reg;
    assign rd_addr = rd_addr_reg;

    // downstream write pass-through
    assign d_wr_rdy = (w_state_reg == W_IDLE) && wr_rdy && resetn;
    assign wr_req   = wr_pass;
    assign wr_type  = wr_pass ? d_wr_type  : 3'd0;
    assign wr_addr  = wr_pass ? d_wr_addr  : 32'd0;
    assign wr_wstrb = wr_pass ? d_wr_wstrb : 4'd0;
    assign wr_data  = wr_pass ? d_wr_data  : 128'd0;

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Testbench for mem_req_arbiter: scoreboard of expected read accepts and
// return beats, fed by a behavioural arbitration model; a monitor pops and
// compares whenever the DUT presents an accept or a return beat.
// Honours ARB_RR_EN the same way as the design.
module tb_mem_req_arbiter;
    localparam int LINE_OFF = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         i_rd_req, d_rd_req;
    logic [2:0]   i_rd_type, d_rd_type;
    logic [31:0]  i_rd_addr, d_rd_addr;
    logic         i_rd_rdy, d_rd_rdy, i_ret_valid, d_ret_valid, i_ret_last, d_ret_last;
    logic [31:0]  ret_data;
    logic         d_wr_req;
    logic [2:0]   d_wr_type;
    logic [31:0]  d_wr_addr;
    logic [3:0]   d_wr_wstrb;
    logic [127:0] d_wr_data;
    logic         d_wr_rdy;
    logic         rd_req;
    logic [2:0]   rd_type;
    logic [31:0]  rd_addr;
    logic         rd_rdy, ret_valid, ret_last;
    logic [31:0]  ret_data_in;
    logic         wr_req;
    logic [2:0]   wr_type;
    logic [31:0]  wr_addr;
    logic [3:0]   wr_wstrb;
    logic [127:0] wr_data;
    logic         wr_rdy, wr_done;

    always #5 clk = ~clk;

    mem_req_arbiter #(.LINE_OFF(LINE_OFF)) dut (
        .clk(clk), .resetn(resetn),
        .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr),
        .i_rd_rdy(i_rd_rdy), .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last),
        .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr),
        .d_rd_rdy(d_rd_rdy), .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last),
        .ret_data(ret_data),
        .d_wr_req(d_wr_req), .d_wr_type(d_wr_type), .d_wr_addr(d_wr_addr),
        .d_wr_wstrb(d_wr_wstrb), .d_wr_data(d_wr_data), .d_wr_rdy(d_wr_rdy),
        .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
        .ret_valid(ret_valid), .ret_last(ret_last), .ret_data_in(ret_data_in),
        .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
        .wr_data(wr_data), .wr_rdy(wr_rdy), .wr_done(wr_done)
    );

    typedef struct {
        bit          side;     // 0 = I, 1 = D
        logic [31:0] addr;
        logic [2:0]  typ;
        bit          overlap;  // must be accepted while the write is still pending
    } acc_t;

    int          checks = 0;
    int          failures = 0;
    acc_t        exp_acc[$];
    logic [31:0] exp_i_data[$], exp_d_data[$];
    bit          exp_i_last[$], exp_d_last[$];
    bit          pend_model = 0;
    logic [31:0] pend_addr_model = 32'd0;
    bit          last_grant_d = 0;
    bit          slave_hold = 0;
    int          slave_beats_left = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a, input int k);
        return ((a ^ 32'h5a5a0000) * 32'h9e3779b1) + (32'(k) * 32'h01010101);
    endfunction

    function automatic int beats_of(input logic [2:0] t);
        return (t == 3'b100) ? 4 : 1;
    endfunction

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return a[31:LINE_OFF] == b[31:LINE_OFF];
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_rd_req"}, rd_req, 0);
        check({tag, "_rd_addr"}, rd_addr, 0);
        check({tag, "_rd_type"}, rd_type, 0);
        check({tag, "_rdy"}, {i_rd_rdy, d_rd_rdy}, 0);
        check({tag, "_ret_valid"}, {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 0);
        check({tag, "_ret_data"}, ret_data, 0);
        check({tag, "_wr"}, {wr_req, d_wr_rdy, wr_type, wr_wstrb}, 0);
        check({tag, "_wr_addr_data"}, {wr_addr, wr_data[95:0]}, 0);
    endtask

    // Monitor: compares every accept pulse and every return beat with the scoreboard.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (resetn) begin
                if (i_rd_rdy || d_rd_rdy) begin
                    if (exp_acc.size() == 0) begin
                        check("unexpected_accept", {i_rd_rdy, d_rd_rdy}, 0);
                    end else begin
                        acc_t e;
                        e = exp_acc.pop_front();
                        check("accept_side", d_rd_rdy, e.side);
                        check("accept_single", i_rd_rdy & d_rd_rdy, 0);
                        check("accept_rd_req", rd_req, 1);
                        check("accept_addr", rd_addr, e.addr);
                        check("accept_type", rd_type, e.typ);
                        if (e.side && pend_model)
                            check("hazard_block", same_line(rd_addr, pend_addr_model), 0);
                        if (e.overlap)
                            check("overlap_write_pending", pend_model, 1);
                        $display("txn read side=%s addr=%08h type=%0d",
                                 d_rd_rdy ? "D" : "I", rd_addr, rd_type);
                    end
                end
                if (i_ret_valid && d_ret_valid)
                    check("ret_both_sides", {i_ret_valid, d_ret_valid}, 2'b10);
                if (i_ret_valid) begin
                    if (exp_i_data.size() == 0) begin
                        check("unexpected_i_ret", i_ret_valid, 0);
                    end else begin
                        check("i_ret_data", ret_data, exp_i_data.pop_front());
                        check("i_ret_last", i_ret_last, exp_i_last.pop_front());
                    end
                end
                if (d_ret_valid) begin
                    if (exp_d_data.size() == 0) begin
                        check("unexpected_d_ret", d_ret_valid, 0);
                    end else begin
                        check("d_ret_data", ret_data, exp_d_data.pop_front());
                        check("d_ret_last", d_ret_last, exp_d_last.pop_front());
                    end
                end
            end
        end
    endtask

    // Downstream memory: random accept delay, random beat gaps, data from address.
    task automatic slave();
        logic [31:0] cur;
        int          beat;
        cur = 32'd0;
        beat = 0;
        forever begin
            @(posedge clk);
            #1;
            rd_rdy = 1'b0;
            ret_valid = 1'b0;
            ret_last = 1'b0;
            ret_data_in = $urandom;
            if (!slave_hold) begin
                if (slave_beats_left > 0) begin
                    if ($urandom_range(0, 3) != 0) begin
                        ret_valid = 1'b1;
                        ret_data_in = mem_word(cur, beat);
                        ret_last = (slave_beats_left == 1);
                        slave_beats_left--;
                        beat++;
                    end
                end else if (rd_req && $urandom_range(0, 2) == 0) begin
                    rd_rdy = 1'b1;
                    cur = rd_addr;
                    beat = 0;
                    slave_beats_left = beats_of(rd_type);
                end
            end
        end
    endtask

    // One requester: raise request after dly cycles, hold until its rdy.
    task automatic requester(input bit side, input logic [31:0] a, input logic [2:0] t, input int dly);
        int n;
        repeat (dly) begin @(posedge clk); #1; end
        if (side) begin d_rd_req = 1'b1; d_rd_addr = a; d_rd_type = t; end
        else      begin i_rd_req = 1'b1; i_rd_addr = a; i_rd_type = t; end
        n = 0;
        forever begin
            @(negedge clk);
            if (side ? d_rd_rdy : i_rd_rdy) break;
            n++;
            if (n > 400) begin
                check(side ? "d_rdy_timeout" : "i_rdy_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        if (side) d_rd_req = 1'b0;
        else      i_rd_req = 1'b0;
    endtask

    // One write: accepted in the first cycle, completion reported after done_dly cycles.
    task automatic writer(input logic [31:0] wa, input int done_dly);
        logic [127:0] wd;
        logic [3:0]   ws;
        wd = {$urandom, $urandom, $urandom, $urandom};
        ws = 4'($urandom_range(1, 15));
        d_wr_req = 1'b1; d_wr_addr = wa; d_wr_type = 3'b010; d_wr_wstrb = ws; d_wr_data = wd;
        wr_rdy = 1'b1;
        @(negedge clk);
        check("wr_accept_rdy", {d_wr_rdy, wr_req}, 2'b11);
        check("wr_pass_addr", wr_addr, wa);
        check("wr_pass_data", wr_data, wd);
        check("wr_pass_ctl", {wr_type, wr_wstrb}, {3'b010, ws});
        $display("txn write addr=%08h wstrb=%h", wa, ws);
        @(posedge clk);
        pend_model = 1'b1;
        pend_addr_model = wa;
        @(negedge clk);
        check("wr_wait_blocks", {d_wr_rdy, wr_req}, 2'b00);
        @(posedge clk);
        #1;
        d_wr_req = 1'b0;
        wr_rdy = 1'b0;
        repeat (done_dly - 2) @(posedge clk);
        #1;
        wr_done = 1'b1;
        @(posedge clk);
        pend_model = 1'b0;
        #1;
        wr_done = 1'b0;
    endtask

    // Holds the downstream off and checks that the presented request stays put.
    task automatic hold_watch(input logic [31:0] da, input int cycles);
        @(posedge clk);
        repeat (cycles) begin
            @(negedge clk);
            check("stall_rd_req", rd_req, 1);
            check("stall_rd_addr", rd_addr, da);
            check("stall_no_rdy", {i_rd_rdy, d_rd_rdy}, 0);
        end
        #2;
        slave_hold = 1'b0;
    endtask

    task automatic push_read(input bit side, input logic [31:0] a, input logic [2:0] t, input bit ov);
        exp_acc.push_back('{side, a, t, ov});
        last_grant_d = side;
        for (int k = 0; k < beats_of(t); k++) begin
            if (side) begin
                exp_d_data.push_back(mem_word(a, k));
                exp_d_last.push_back(k == beats_of(t) - 1);
            end else begin
                exp_i_data.push_back(mem_word(a, k));
                exp_i_last.push_back(k == beats_of(t) - 1);
            end
        end
    endtask

    // One scenario: optional I read, optional D read, optional write, optional stall.
    task automatic run_txn(input bit use_i, input logic [31:0] ia, input logic [2:0] it, input int i_dly,
                           input bit use_d, input logic [31:0] da, input logic [2:0] dt, input int d_dly,
                           input bit do_wr, input logic [31:0] wa, input int done_dly, input int hold);
        bit haz, d_first, ov;
        int n;
        haz = do_wr && use_d && same_line(da, wa);
        ov  = do_wr && use_d && !haz && !use_i;
        d_first = use_d;
        if (use_i && use_d) begin
            if (haz)                d_first = 1'b0;
            else if (i_dly > d_dly) d_first = 1'b1;
            else if (d_dly > i_dly) d_first = 1'b0;
            else begin
`ifdef ARB_RR_EN
                d_first = !last_grant_d;
`else
                d_first = 1'b1;
`endif
            end
        end
        if (d_first) begin
            push_read(1'b1, da, dt, ov);
            if (use_i) push_read(1'b0, ia, it, 1'b0);
        end else begin
            if (use_i) push_read(1'b0, ia, it, 1'b0);
            if (use_d) push_read(1'b1, da, dt, ov);
        end
        if (hold > 0) slave_hold = 1'b1;
        @(posedge clk);
        #1;
        fork
            begin if (do_wr) writer(wa, done_dly); end
            begin if (use_i) requester(1'b0, ia, it, i_dly); end
            begin if (use_d) requester(1'b1, da, dt, d_dly); end
            begin if (hold > 0) hold_watch(da, hold); end
        join
        n = 0;
        while ((exp_acc.size() + exp_i_data.size() + exp_d_data.size()) != 0 && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if ((exp_acc.size() + exp_i_data.size() + exp_d_data.size()) != 0) begin
            check("drain_timeout", exp_acc.size() + exp_i_data.size() + exp_d_data.size(), 0);
            exp_acc.delete(); exp_i_data.delete(); exp_d_data.delete();
            exp_i_last.delete(); exp_d_last.delete();
        end
    endtask

    // Reset asserted in the middle of a 4-beat I response.
    task automatic reset_mid_response();
        int n;
        push_read(1'b0, 32'h1fc00040, 3'b100, 1'b0);
        @(posedge clk);
        #1;
        requester(1'b0, 32'h1fc00040, 3'b100, 0);
        n = 0;
        while (exp_i_data.size() > 2 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("reset_reached_beat2", exp_i_data.size(), 2);
        slave_hold = 1'b1;
        d_wr_req = 1'b1; d_wr_addr = 32'h00006000; wr_rdy = 1'b1;
        resetn = 1'b0;
        #1;
        check_outputs_zero("midreset");
        exp_i_data.delete(); exp_i_last.delete(); exp_acc.delete();
        pend_model = 1'b0;
        last_grant_d = 1'b0;
        d_wr_req = 1'b0; wr_rdy = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b1;
        @(negedge clk);
        check("after_release_rd_req", rd_req, 0);
        slave_hold = 1'b0;
        n = 0;
        while (slave_beats_left > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stray_beats_sent", slave_beats_left, 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int mode;
        logic [31:0] ia, da, wa;
        logic [2:0]  it, dt;
        logic [2:0]  types [4];
        types[0] = 3'b000; types[1] = 3'b001; types[2] = 3'b010; types[3] = 3'b100;

        resetn = 1'b0;
        i_rd_req = 0; i_rd_type = 0; i_rd_addr = 0;
        d_rd_req = 0; d_rd_type = 0; d_rd_addr = 0;
        d_wr_req = 0; d_wr_type = 0; d_wr_addr = 0; d_wr_wstrb = 0; d_wr_data = 0;
        rd_rdy = 0; ret_valid = 0; ret_last = 0; ret_data_in = 0;
        wr_rdy = 0; wr_done = 0;

        fork
            monitor();
            slave();
        join_none

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        #2;
        resetn = 1'b1;

        // single I line read
        run_txn(1, 32'h1fc00010, 3'b100, 0, 0, 32'h0, 3'b000, 0, 0, 32'h0, 0, 0);
        // single D word read, then simultaneous I and D requests twice
        run_txn(0, 32'h0, 3'b000, 0, 1, 32'h00000800, 3'b010, 0, 0, 32'h0, 0, 0);
        run_txn(1, 32'h00001000, 3'b010, 0, 1, 32'h00001000, 3'b010, 0, 0, 32'h0, 0, 0);
        run_txn(1, 32'h1fc00020, 3'b100, 1, 1, 32'h00001010, 3'b100, 1, 0, 32'h0, 0, 0);
        // write pending, D read to the same line issued next cycle
        run_txn(0, 32'h0, 3'b000, 0, 1, 32'h0000200c, 3'b010, 1, 1, 32'h00002004, 10, 0);
        // write pending, D read to another line overlaps the write
        run_txn(0, 32'h0, 3'b000, 0, 1, 32'h00003000, 3'b010, 1, 1, 32'h00002004, 30, 0);
        // same-cycle write accept and D read to one line, I read granted instead
        run_txn(1, 32'h1fc00100, 3'b100, 0, 1, 32'h00004008, 3'b100, 0, 1, 32'h00004000, 10, 0);
        // downstream stalls 20 cycles with D presented and an I request waiting
        run_txn(1, 32'h1fc00200, 3'b010, 1, 1, 32'h00005000, 3'b100, 0, 0, 32'h0, 0, 20);
        // reset in the middle of a response
        reset_mid_response();

        // randomized scenarios
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(0, 5);
            ia = 32'h1fc00000 | ($urandom & 32'h00000ffc);
            da = $urandom & 32'h00003ffc;
            wa = $urandom & 32'h00003ffc;
            it = types[$urandom_range(0, 3)];
            dt = types[$urandom_range(0, 3)];
            case (mode)
                0: run_txn(1, ia, it, 0, 0, da, dt, 0, 0, wa, 0, 0);
                1: run_txn(0, ia, it, 0, 1, da, dt, 0, 0, wa, 0, 0);
                2: begin
                    int k;
                    k = $urandom_range(0, 1);
                    run_txn(1, ia, it, k, 1, da, dt, k, 0, wa, 0, 0);
                end
                3: begin
                    int k;
                    k = $urandom_range(0, 1);
                    run_txn(1, ia, it, k, 1, da, dt, 1 - k, 0, wa, 0, 0);
                end
                4: begin
                    da = {wa[31:LINE_OFF], 4'($urandom_range(0, 3) * 4)};
                    run_txn($urandom_range(0, 1) == 1, ia, it, $urandom_range(0, 1),
                            1, da, dt, $urandom_range(0, 1), 1, wa, $urandom_range(6, 14), 0);
                end
                default: begin
                    da = wa ^ 32'h00000100;
                    run_txn(0, ia, it, 0, 1, da, dt, $urandom_range(0, 1), 1, wa, 30, 0);
                end
            endcase
        end

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
